mem_wr_arbiter: RTL and testbench



---
 rtl/mem_wr_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_wr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_wr_arbiter
//
// Merges two independent write-request streams (ports A and B) into the single
// registered write port of the register-file memory. Each port has its own
// small in-order FIFO with valid/ready flow control. The two FIFO heads are
// served round-robin, one memory write per cycle.
//
// Optional feature: define MEM_WR_ARB_MERGE_EN to merge an accepted write into
// the FIFO tail entry when both target the same address and that tail is not
// being popped on the same edge. The tail's data is replaced and the count is
// left unchanged.
//
// Ports:
//   clk                 sole clock, rising edge
//   rst_n               asynchronous active-low reset
//   a_valid/a_ready     port A handshake (a_ready is a flop)
//   a_addr/a_data       port A write address/data
//   b_valid/b_ready     port B handshake (b_ready is a flop)
//   b_addr/b_data       port B write address/data
//   mem_we              registered memory write strobe
//   mem_addr/mem_din    registered memory write address/data (hold when idle)
//   idle                both FIFOs empty and mem_we low
// -----------------------------------------------------------------------------
module mem_wr_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Port-indexed views of the two request streams (index 0 = A, 1 = B).
  logic [1:0]        in_valid;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];

  assign in_valid   = {b_valid, a_valid};
  assign in_addr[0] = a_addr;
  assign in_addr[1] = b_addr;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  logic [1:0]        port_ready;
  logic [1:0]        nonempty;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] head_addr [2];
  logic [DATA_W-1:0] head_data [2];

  // ---------------------------------------------------------------------------
  // Per-port FIFO
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              push;
    logic              merge;
    logic              store;
`ifdef MEM_WR_ARB_MERGE_EN
    logic [PTR_W-1:0]  tail_ptr;
`endif

    always_comb begin
      push  = in_valid[gi] && ready_q;
`ifdef MEM_WR_ARB_MERGE_EN
      tail_ptr = wr_ptr_q - PTR_W'(1);
      // A tail that is also the head being popped this edge leaves the FIFO,
      // so it cannot absorb the new write.
      merge = push && (count_q != '0) &&
              (addr_mem_q[tail_ptr] == in_addr[gi]) &&
              !((count_q == CNT_W'(1)) && grant[gi]);
`else
      merge = 1'b0;
`endif
      store    = push && !merge;
      count_d  = count_q + CNT_W'(store) - CNT_W'(grant[gi]);
      wr_ptr_d = wr_ptr_q + PTR_W'(store);
      rd_ptr_d = rd_ptr_q + PTR_W'(grant[gi]);
      // Ready looks only at the next count so there is no combinational path
      // from valid or the memory side.
      ready_d  = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ready_q  <= 1'b0;
      end else begin
        count_q  <= count_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        ready_q  <= ready_d;
      end
    end

    // Entry storage carries no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
      if (store) begin
        addr_mem_q[wr_ptr_q] <= in_addr[gi];
        data_mem_q[wr_ptr_q] <= in_data[gi];
      end
`ifdef MEM_WR_ARB_MERGE_EN
      if (merge) begin
        data_mem_q[tail_ptr] <= in_data[gi];
      end
`endif
    end

    assign port_ready[gi] = ready_q;
    assign nonempty[gi]   = (count_q != '0);
    assign head_addr[gi]  = addr_mem_q[rd_ptr_q];
    assign head_data[gi]  = data_mem_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration and registered memory write port
  // ---------------------------------------------------------------------------
  logic              rr_q, rr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;

  always_comb begin
    // rr only matters when both heads are present.
    grant[0] = nonempty[0] && (!nonempty[1] || !rr_q);
    grant[1] = nonempty[1] && (!nonempty[0] ||  rr_q);

    rr_d       = rr_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    if (grant[0]) begin
      rr_d       = 1'b1;
      mem_we_d   = 1'b1;
      mem_addr_d = head_addr[0];
      mem_din_d  = head_data[0];
    end else if (grant[1]) begin
      rr_d       = 1'b0;
      mem_we_d   = 1'b1;
      mem_addr_d = head_addr[1];
      mem_din_d  = head_data[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign a_ready  = port_ready[0];
  assign b_ready  = port_ready[1];
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign idle     = !nonempty[0] && !nonempty[1] && !mem_we_q;

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_wr_arbiter
//
// Directed, self-checking bench for mem_wr_arbiter (ADDR_W=4, DATA_W=8,
// DEPTH=2). Expected values are hand-derived; issued memory writes are logged
// on the falling edge and compared against hand-built expected sequences.
// Honours MEM_WR_ARB_MERGE_EN for the merge scenario.
// -----------------------------------------------------------------------------
module tb_mem_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [3:0] a_addr = '0;
  logic [7:0] a_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [3:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic       idle;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] log_q [$];

  mem_wr_arbiter #(.ADDR_W(4), .DATA_W(8), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  // Record every issued write, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && mem_we) log_q.push_back({mem_addr, mem_din});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ia, ib, n5;
    logic ra, rb;
    logic [11:0] exp_e;
    logic [7:0]  d5 [2];
    logic [3:0]  t6_addr [3];
    logic [7:0]  t6_data [3];

    // ---- Reset values and ready after release ----
    repeat (2) tick();
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din",  32'(mem_din),  32'd0);
    chk("rst_a_ready",  32'(a_ready),  32'd0);
    chk("rst_b_ready",  32'(b_ready),  32'd0);
    chk("rst_idle",     32'(idle),     32'd1);
    rst_n = 1'b1;
    tick();
    chk("rel_a_ready", 32'(a_ready), 32'd1);
    chk("rel_b_ready", 32'(b_ready), 32'd1);
    $display("reset: ready rose after release");

    // ---- Simultaneous first requests: A then B ----
    a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 8'h22;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("sim_we0", 32'(mem_we), 32'd0);
    tick();
    chk("sim_first_we",   32'(mem_we),   32'd1);
    chk("sim_first_addr", 32'(mem_addr), 32'd1);
    chk("sim_first_din",  32'(mem_din),  32'h11);
    tick();
    chk("sim_second_we",   32'(mem_we),   32'd1);
    chk("sim_second_addr", 32'(mem_addr), 32'd2);
    chk("sim_second_din",  32'(mem_din),  32'h22);
    tick();
    chk("sim_done_we",   32'(mem_we), 32'd0);
    chk("sim_done_idle", 32'(idle),   32'd1);
    $display("simultaneous: A(1,11) then B(2,22)");

    // ---- Backpressure, alternation, no loss ----
    log_q.delete();
    ia = 0; ib = 0;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_addr = ia[3:0];        a_data = 8'hA0 + ia[7:0];
      b_valid = 1'b1; b_addr = 4'd8 + ib[3:0]; b_data = 8'hB0 + ib[7:0];
      ra = a_ready; rb = b_ready;
      tick();
      if (ra) ia++;
      if (rb) ib++;
      chk($sformatf("bp_a_ready_%0d", i), 32'(a_ready), (i == 0) ? 32'd1 : 32'(i % 2 == 1));
      chk($sformatf("bp_b_ready_%0d", i), 32'(b_ready), (i == 0) ? 32'd1 : 32'(i % 2 == 0));
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (6) tick();
    chk("bp_a_accepted", 32'(ia), 32'd5);
    chk("bp_b_accepted", 32'(ib), 32'd5);
    chk("bp_issued", 32'(log_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < log_q.size(); k++) begin
      if (k % 2 == 0) exp_e = {4'(k / 2), 8'hA0 + 8'(k / 2)};
      else            exp_e = {4'd8 + 4'(k / 2), 8'hB0 + 8'(k / 2)};
      chk($sformatf("bp_write_%0d", k), 32'(log_q[k]), 32'(exp_e));
    end
    $display("backpressure: %0d writes issued alternating A,B", log_q.size());

    // ---- Reset with queued entries ----
    a_valid = 1'b1; a_addr = 4'd6; a_data = 8'h66;
    b_valid = 1'b1; b_addr = 4'd7; b_data = 8'h77;
    repeat (3) tick();
    chk("q_we_before_rst", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("q_rst_we",      32'(mem_we),   32'd0);
    chk("q_rst_addr",    32'(mem_addr), 32'd0);
    chk("q_rst_din",     32'(mem_din),  32'd0);
    chk("q_rst_a_ready", 32'(a_ready),  32'd0);
    chk("q_rst_b_ready", 32'(b_ready),  32'd0);
    chk("q_rst_idle",    32'(idle),     32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    log_q.delete();
    tick();
    chk("q_rel_a_ready", 32'(a_ready), 32'd1);
    chk("q_rel_b_ready", 32'(b_ready), 32'd1);
    repeat (6) tick();
    chk("q_no_writes", 32'(log_q.size()), 32'd0);
    chk("q_idle",      32'(idle),         32'd1);
    $display("reset with queue: %0d writes after release", log_q.size());

    // ---- Single write latency ----
    a_valid = 1'b1; a_addr = 4'd3; a_data = 8'h5A;
    tick();
    a_valid = 1'b0;
    chk("lat_we_k", 32'(mem_we), 32'd0);
    tick();
    chk("lat_we",   32'(mem_we),   32'd1);
    chk("lat_addr", 32'(mem_addr), 32'd3);
    chk("lat_din",  32'(mem_din),  32'h5A);
    chk("lat_busy", 32'(idle),     32'd0);
    tick();
    chk("lat_we_off", 32'(mem_we), 32'd0);
    chk("lat_idle",   32'(idle),   32'd1);
    $display("latency: write addr 3 data 5a issued once");

    // ---- Merge scenario: B streaming, A hits addr 5 twice ----
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    log_q.delete();
    t6_addr[0] = 4'd4; t6_data[0] = 8'h44;
    t6_addr[1] = 4'd5; t6_data[1] = 8'h11;
    t6_addr[2] = 4'd5; t6_data[2] = 8'h22;
    ia = 0; ib = 0;
    for (int i = 0; i < 12; i++) begin
      a_valid = (ia < 3);
      if (ia < 3) begin a_addr = t6_addr[ia]; a_data = t6_data[ia]; end
      b_valid = (ib < 6);
      b_addr = 4'd8 + ib[3:0]; b_data = 8'hC0 + ib[7:0];
      ra = a_ready; rb = b_ready;
      tick();
      if (a_valid && ra) ia++;
      if (b_valid && rb) ib++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (6) tick();
    chk("mg_a_accepted", 32'(ia), 32'd3);
    chk("mg_b_accepted", 32'(ib), 32'd6);
    n5 = 0;
    d5[0] = '0; d5[1] = '0;
    foreach (log_q[k]) begin
      if (log_q[k][11:8] == 4'd5) begin
        if (n5 < 2) d5[n5] = log_q[k][7:0];
        n5++;
      end
    end
`ifdef MEM_WR_ARB_MERGE_EN
    chk("mg_issued",  32'(log_q.size()), 32'd8);
    chk("mg_n_addr5", 32'(n5),           32'd1);
    chk("mg_data0",   32'(d5[0]),        32'h22);
`else
    chk("mg_issued",  32'(log_q.size()), 32'd9);
    chk("mg_n_addr5", 32'(n5),           32'd2);
    chk("mg_data0",   32'(d5[0]),        32'h11);
    chk("mg_data1",   32'(d5[1]),        32'h22);
`endif
    $display("merge scenario: %0d writes to addr 5, %0d total", n5, log_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
